aes_round_seq: RTL and testbench

Iterative AES-128 encryption controller that sequences a single shared round datapath over 11 cycles, one cycle per round index 0..10. The round datapath is SubBytes, ShiftRows, MixColumns and AddRoundKey plus one key-expansion step. The block holds the cipher state and current round key in registers. Index 0 is key whitening only, 1..9 are full rounds, and 10 is the final round without MixColumns. It accepts one {key, message} block through a valid/ready handshake and returns the ciphertext through a second valid/ready handshake. It replaces the per-round unrolled instances where area, not latency, matters.

---
 rtl/aes_pkg.sv | 120 ++++++++++++
 rtl/aes_round_core.sv | 33 +++
 rtl/aes_round_seq.sv | 103 ++++++++++
 tb/tb_aes_round_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: controller states, block type, round constants
// and the byte-level transforms used by the iterative round datapath.
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for key-expansion step idx (1..10); zero elsewhere.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // SubBytes: S-box applied independently to all 16 bytes.
  function automatic block_t sub_bytes(input block_t s);
    block_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
    end
    return r;
  endfunction

  // ShiftRows: byte index is 4*column + row; row r rotates left by r columns.
  function automatic block_t shift_rows(input block_t s);
    block_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
      end
    end
    return r;
  endfunction

  // MixColumns: each 32-bit column multiplied by the fixed {02,03,01,01} matrix.
  function automatic block_t mix_columns(input block_t s);
    block_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // One AES-128 key-schedule step; rcon lands on byte 0 of the RotWord/SubWord term.
  function automatic block_t key_expand(input block_t rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;
    w0   = rk[127:96];
    w1   = rk[95:64];
    w2   = rk[63:32];
    w3   = rk[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
           ^ {rcon, 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_round_core.sv
// Combinational AES-128 round with a runtime round index, plus the matching
// key-schedule step, so one instance can serve every round of an encryption.
module aes_round_core
  import aes_pkg::*;
(
  input  block_t     st_i,
  input  block_t     rk_i,
  input  logic [3:0] rnd_i,
  output block_t     round_out_o,
  output block_t     next_rk_o
);

  block_t     sb;
  block_t     sr;
  block_t     mc;
  logic [7:0] rcon;

  // Round 0 is plain whitening, the last round skips MixColumns, the rest are full.
  always_comb begin
    sb   = sub_bytes(st_i);
    sr   = shift_rows(sb);
    mc   = mix_columns(sr);
    rcon = rcon_lookup(rnd_i + 4'd1);
    round_out_o = st_i ^ rk_i;
    if (rnd_i == 4'(NR_AES128)) begin
      round_out_o = sr ^ rk_i;
    end else if (rnd_i != 4'd0) begin
      round_out_o = mc ^ rk_i;
    end
    next_rk_o = key_expand(rk_i, rcon);
  end

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES-128 encryptor: one shared round datapath stepped over
// round indices 0..10, with valid/ready handshakes on both sides.
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] s_input,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [3:0]   round
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes_round_seq: only NR=10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_RND = 4'(NR_AES128);

  aes_state_e state_q, state_d;
  block_t     st_q, st_d;
  block_t     rk_q, rk_d;
  block_t     o_q, o_d;
  logic [3:0] rnd_q, rnd_d;

  block_t     round_out;
  block_t     next_rk;

  aes_round_core u_core (
    .st_i        (st_q),
    .rk_i        (rk_q),
    .rnd_i       (rnd_q),
    .round_out_o (round_out),
    .next_rk_o   (next_rk)
  );

  // Next-state logic: capture a block in IDLE, step a round per cycle in RUN,
  // hold the ciphertext in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    o_d     = o_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = s_input[127:0];
          rk_d    = s_input[255:128];
          rnd_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d  = round_out;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          o_d     = round_out;
          rnd_d   = 4'd0;
          state_d = DONE;
        end else begin
          rk_d = next_rk;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      o_q     <= '0;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      o_q     <= o_d;
      rnd_q   <= rnd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign round     = (state_q == RUN) ? rnd_q : 4'd0;
  assign o         = o_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for the iterative AES-128 encryptor using FIPS-197 vectors.
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] s_input;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] o;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [3:0]   round;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] msg;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  aes_round_seq #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_input   (s_input),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .round     (round)
  );

  // Compare one value against its expected value and keep the tallies.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present a block while IDLE and return #1 after the accepting edge.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] msg);
    s_input  = {key, msg};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid, checking the round index sequence.
  task automatic waitDone(output int lat, output bit roundOk);
    lat     = 0;
    roundOk = (round == 4'd0) && busy;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat <= 10 && round != 4'(lat)) roundOk = 1'b0;
    end
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           lat;
    bit           roundOk;
    bit           okFlag;
    logic [127:0] hold;
    int           acc;
    int           outs;
    int           cyc;
    int           acceptAt[3];
    logic         wasReady;
    logic         wasValid;

    vecs[0] = '{"appB",  128'h2b7e151628aed2a6abf7158809cf4f3c,
                         128'h3243f6a8885a308d313198a2e0370734,
                         128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{"appC1", 128'h000102030405060708090a0b0c0d0e0f,
                         128'h00112233445566778899aabbccddeeff,
                         128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{"zero",  128'h0,
                         128'h0,
                         128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    s_input   = '0;
    #12;
    checkOutput("reset o",         o,         128'h0);
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset busy",      busy,      1'b0);
    checkOutput("reset round",     round,     4'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset in_ready",  in_ready,  1'b1);

    // Table-driven encryptions with the consumer always ready.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i].key, vecs[i].msg);
      waitDone(lat, roundOk);
      checkOutput({vecs[i].name, " ct"},          o,       vecs[i].ct);
      checkOutput({vecs[i].name, " latency"},     lat,     11);
      checkOutput({vecs[i].name, " round steps"}, roundOk, 1'b1);
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, " back to idle"}, in_ready, 1'b1);
    end

    // Backpressure: DONE holds with a stable ciphertext.
    out_ready = 1'b0;
    applyStimulus(vecs[2].key, vecs[2].msg);
    waitDone(lat, roundOk);
    checkOutput("bp ct", o, vecs[2].ct);
    hold   = o;
    okFlag = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (o !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) okFlag = 1'b0;
    end
    checkOutput("bp stable", okFlag, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp release out_valid", out_valid, 1'b0);
    checkOutput("bp release in_ready",  in_ready,  1'b1);

    // Input changes and held in_valid during RUN must not disturb the block.
    s_input  = {vecs[0].key, vecs[0].msg};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    s_input = {vecs[1].key, vecs[1].msg};
    waitDone(lat, roundOk);
    checkOutput("hold ct1",      o,   vecs[0].ct);
    checkOutput("hold latency1", lat, 11);
    @(posedge clk);
    #1;
    checkOutput("hold idle before second", in_ready, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("hold second accepted", {busy, round}, {1'b1, 4'd0});
    in_valid = 1'b0;
    waitDone(lat, roundOk);
    checkOutput("hold ct2",      o,   vecs[1].ct);
    checkOutput("hold latency2", lat, 11);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN aborts the block.
    applyStimulus(vecs[0].key, vecs[0].msg);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort at round 5", round, 4'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("abort o",         o,         128'h0);
    checkOutput("abort out_valid", out_valid, 1'b0);
    checkOutput("abort busy",      busy,      1'b0);
    checkOutput("abort round",     round,     4'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("abort in_ready", in_ready, 1'b1);
    okFlag = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) okFlag = 1'b0;
    end
    checkOutput("abort no out_valid", okFlag, 1'b1);
    applyStimulus(vecs[1].key, vecs[1].msg);
    waitDone(lat, roundOk);
    checkOutput("after abort ct", o, vecs[1].ct);
    @(posedge clk);
    #1;

    // Back-to-back blocks with in_valid and out_ready held high.
    acc         = 0;
    outs        = 0;
    cyc         = 0;
    acceptAt    = '{0, 0, 0};
    out_ready   = 1'b1;
    s_input     = {vecs[0].key, vecs[0].msg};
    in_valid    = 1'b1;
    for (int k = 0; k < 60 && outs < 3; k++) begin
      wasReady = in_ready;
      wasValid = in_valid;
      @(posedge clk);
      #1;
      cyc++;
      if (wasReady && wasValid && acc < 3) begin
        acceptAt[acc] = cyc;
        acc++;
        if (acc < 3) s_input = {vecs[acc].key, vecs[acc].msg};
        else in_valid = 1'b0;
      end
      if (out_valid && outs < 3) begin
        checkOutput({"b2b ct ", vecs[outs].name}, o, vecs[outs].ct);
        outs++;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b outputs",  outs, 3);
    checkOutput("b2b gap 0-1",  acceptAt[1] - acceptAt[0], 13);
    checkOutput("b2b gap 1-2",  acceptAt[2] - acceptAt[1], 13);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
